// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end types and constants
// Provides the fetch FSM state enum, instruction width and default NOP word.
// Also supplies a default for the `A_BITS address-width macro when the build does not set it.
`ifndef A_BITS
`define A_BITS 8
`endif

package cpu_pkg;

   localparam int INSTR_BITS = 16;
   localparam logic [INSTR_BITS-1:0] NOP_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller (PC, IR, BOOT/RUN/HALTED FSM)
// Ports:
//   clk_i, rst_i           clock and synchronous active-high reset
//   stall_i                downstream cannot accept a new instruction
//   jmp_i, jmp_addr_i      redirect request and target
//   halt_i, resume_i       enter and leave HALTED
//   step_i                 single-step in HALTED (only with FETCH_CTRL_STEP_EN)
//   instruction_i          combinational memory word at pc_o
//   pc_o                   current fetch address
//   fetch_instruction_o    instruction register to decode
//   halted_o, state_o      status / debug
// Build option: FETCH_CTRL_STEP_EN enables single-step from HALTED.
`ifndef A_BITS
`define A_BITS 8
`endif

module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [`A_BITS-1:0]    RESET_PC = '0,
   parameter logic [INSTR_BITS-1:0] NOP_WORD = NOP_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  logic                  jmp_i,
   input  logic [`A_BITS-1:0]    jmp_addr_i,
   input  logic                  halt_i,
   input  logic                  resume_i,
`ifdef FETCH_CTRL_STEP_EN
   input  logic                  step_i,
`endif
   input  logic [INSTR_BITS-1:0] instruction_i,
   output logic [`A_BITS-1:0]    pc_o,
   output logic [INSTR_BITS-1:0] fetch_instruction_o,
   output logic                  halted_o,
   output logic [1:0]            state_o
);

   localparam logic [`A_BITS-1:0] PC_ONE = {{(`A_BITS-1){1'b0}}, 1'b1};

   fetch_state_t              state_q, state_nxt;
   logic [`A_BITS-1:0]        pc_q, pc_nxt;
   logic [INSTR_BITS-1:0]     ir_q, ir_nxt;

   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      ir_nxt    = ir_q;
      case (state_q)
         ST_BOOT: begin
            ir_nxt    = NOP_WORD;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Stall wins outright: decode keeps jmp/halt asserted from the held IR,
            // so they are serviced once the stall clears.
            if (stall_i) begin
               pc_nxt = pc_q;
            end else if (jmp_i) begin
               pc_nxt = jmp_addr_i;
               ir_nxt = NOP_WORD;
            end else if (halt_i) begin
               ir_nxt    = NOP_WORD;
               state_nxt = ST_HALTED;
            end else begin
               pc_nxt = pc_q + PC_ONE;
               ir_nxt = instruction_i;
            end
         end
         ST_HALTED: begin
            // Leaving HALTED performs the fetch from the held PC in the same cycle.
            if (resume_i) begin
               pc_nxt    = pc_q + PC_ONE;
               ir_nxt    = instruction_i;
               state_nxt = ST_RUN;
            end
`ifdef FETCH_CTRL_STEP_EN
            else if (step_i) begin
               pc_nxt = pc_q + PC_ONE;
               ir_nxt = instruction_i;
            end
`endif
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) pc_q <= RESET_PC;
      else       pc_q <= pc_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ir_q <= NOP_WORD;
      else       ir_q <= ir_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_BOOT;
      else       state_q <= state_nxt;
   end

   assign pc_o                = pc_q;
   assign fetch_instruction_o = ir_q;
   assign state_o             = state_q;
   assign halted_o            = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
`ifndef A_BITS
`define A_BITS 8
`endif

module tb_fetch_ctrl;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 stall = 1'b0;
   logic                 jmp = 1'b0;
   logic [`A_BITS-1:0]   jmp_addr = '0;
   logic                 halt = 1'b0;
   logic                 resume = 1'b0;
`ifdef FETCH_CTRL_STEP_EN
   logic                 step_req = 1'b0;
`endif
   logic [15:0]          instr;
   logic [`A_BITS-1:0]   pc;
   logic [15:0]          ir;
   logic                 halted;
   logic [1:0]           state;

   logic [15:0]          mem [0:(1<<`A_BITS)-1];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign instr = mem[pc];

   fetch_ctrl dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .stall_i             (stall),
      .jmp_i               (jmp),
      .jmp_addr_i          (jmp_addr),
      .halt_i              (halt),
      .resume_i            (resume),
`ifdef FETCH_CTRL_STEP_EN
      .step_i              (step_req),
`endif
      .instruction_i       (instr),
      .pc_o                (pc),
      .fetch_instruction_o (ir),
      .halted_o            (halted),
      .state_o             (state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ir,
                          input logic [31:0] e_state);
      chk({tag, "_pc"}, 32'(pc), e_pc);
      chk({tag, "_ir"}, 32'(ir), e_ir);
      chk({tag, "_state"}, 32'(state), e_state);
      chk({tag, "_halted"}, 32'(halted), (e_state == 2) ? 32'd1 : 32'd0);
   endtask

   initial begin
      for (int i = 0; i < (1 << `A_BITS); i++) mem[i] = 16'(i + 16'h100);

      // reset
      rst = 1'b1;
      tick();
      chk_all("reset", 0, 16'h0000, 0);
      rst = 1'b0;

      // boot and sequential fetch
      tick(); chk_all("boot", 0, 16'h0000, 1);
      tick(); chk_all("seq1", 1, 16'h0100, 1);
      tick(); chk_all("seq2", 2, 16'h0101, 1);
      tick(); chk_all("seq3", 3, 16'h0102, 1);
      tick(); tick();
      chk_all("seq5", 5, 16'h0104, 1);

      // jump at pc=5 to 0x20
      jmp = 1'b1; jmp_addr = 'h20;
      tick(); chk_all("jmp", 'h20, 16'h0000, 1);
      jmp = 1'b0;
      tick(); chk_all("jmp_next", 'h21, 16'h0120, 1);

      // stall with jump pending
      stall = 1'b1; jmp = 1'b1; jmp_addr = 'h40;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_all("stall", 'h21, 16'h0120, 1);
      end
      stall = 1'b0;
      tick(); chk_all("stall_jmp", 'h40, 16'h0000, 1);

      // halt at pc=7
      jmp_addr = 'h07;
      tick(); chk_all("jmp7", 7, 16'h0000, 1);
      jmp = 1'b0; halt = 1'b1;
      tick(); chk_all("halt", 7, 16'h0000, 2);
      halt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         jmp = i[0]; stall = i[1]; halt = i[2]; jmp_addr = 'h55;
         tick(); chk_all("halted_hold", 7, 16'h0000, 2);
      end
      jmp = 1'b0; stall = 1'b0; halt = 1'b0;
      resume = 1'b1;
      tick(); chk_all("resume", 8, 16'h0107, 1);
      resume = 1'b0;

      // PC wrap
      jmp = 1'b1; jmp_addr = '1;
      tick(); chk_all("jmp_ff", (1 << `A_BITS) - 1, 16'h0000, 1);
      jmp = 1'b0;
      tick(); chk_all("wrap", 0, 16'(((1 << `A_BITS) - 1) + 16'h100), 1);

      // reset during a jump cycle
      jmp = 1'b1; jmp_addr = 'h33; rst = 1'b1;
      tick(); chk_all("rst_jmp", 0, 16'h0000, 0);
      jmp = 1'b0; rst = 1'b0;
      tick(); chk_all("rst_jmp_boot", 0, 16'h0000, 1);

`ifdef FETCH_CTRL_STEP_EN
      // single-step twice from HALTED at pc=2
      tick(); tick();
      halt = 1'b1;
      tick(); chk_all("step_halt", 2, 16'h0000, 2);
      halt = 1'b0;
      step_req = 1'b1;
      tick(); chk_all("step1", 3, 16'h0102, 2);
      step_req = 1'b0;
      tick(); chk_all("step_idle", 3, 16'h0102, 2);
      step_req = 1'b1;
      tick(); chk_all("step2", 4, 16'h0103, 2);
      step_req = 1'b1; resume = 1'b1;
      tick(); chk_all("resume_prio", 5, 16'h0104, 1);
      step_req = 1'b0; resume = 1'b0;
`endif

      // reset while HALTED
      halt = 1'b1;
      tick(); chk("pre_rst_halted", 32'(halted), 1);
      halt = 1'b0; rst = 1'b1;
      tick(); chk_all("rst_halted", 0, 16'h0000, 0);
      rst = 1'b0;
      tick(); chk_all("rst_halted_boot", 0, 16'h0000, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset and used in BOOT.
REQ-002 SHALL have parameter NOP_WORD, default 16'h0000, meaning instruction word forced into IR on flush.
REQ-003 SHALL have port clk_i  in  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall_i  in  1  downstream cannot accept a new instruction this cycle.
REQ-006 SHALL have port jmp_i  in  1  decode requests redirect; qualified by jmp_addr_i.
REQ-007 SHALL have port jmp_addr_i  in  `A_BITS  redirect target address.
REQ-008 SHALL have port halt_i  in  1  HALT instruction decoded.
REQ-009 SHALL have port resume_i  in  1  leave HALTED.
REQ-010 SHALL have port step_i  in  1  single-step request; present only with FETCH_CTRL_STEP_EN.
REQ-011 SHALL have port instruction_i  in  16  word read from instruction memory at pc_o, combinational memory.
REQ-012 SHALL have port pc_o  out  `A_BITS  current fetch address.
REQ-013 SHALL have port fetch_instruction_o  out  16  instruction register to decode.
REQ-014 SHALL have port halted_o  out  1  high while in HALTED.
REQ-015 SHALL have port state_o  out  2  encoded FSM state, for debug.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HALTED; state_o encodes BOOT=0, RUN=1, HALTED=2.
REQ-017 BOOT SHALL last exactly one cycle: pc_o held, IR loaded with NOP_WORD, next state RUN.
REQ-018 RUN event priority SHALL be stall_i > jmp_i > halt_i > sequential.
REQ-019 RUN+stall_i: pc_o and IR hold; jmp_i/halt_i ignored, since decode keeps them asserted from the held IR.
REQ-020 RUN+jmp_i: pc_o <= jmp_addr_i; IR <= NOP_WORD, squashing the wrong-path word; state stays RUN.
REQ-021 RUN+halt_i: pc_o held; IR <= NOP_WORD, so HALT is not re-decoded; next state HALTED.
REQ-022 RUN sequential: pc_o <= pc_o+1; IR <= instruction_i; one-cycle fetch-to-decode latency.
REQ-023 PC increment SHALL be modulo 2^`A_BITS; all-ones wraps to 0 without flag.
REQ-024 HALTED: pc_o and IR hold, halted_o=1; resume_i -> RUN next cycle, first fetch is from the held pc_o.
REQ-025 HALTED SHALL ignore jmp_i, halt_i and stall_i.
REQ-026 Unused state encoding SHALL return to BOOT next cycle.

Reset
REQ-027 rst_i high at a rising edge: pc_o=RESET_PC, fetch_instruction_o=NOP_WORD, state=BOOT, halted_o=0, regardless of current state or pending requests.
REQ-028 Reset asserted mid-jump, mid-stall or in HALTED SHALL discard that operation completely.

Configuration
REQ-029 Macro FETCH_CTRL_STEP_EN defined: in HALTED with step_i=1 and resume_i=0, one sequential fetch (pc_o+1, IR <= instruction_i); state stays HALTED.
REQ-030 resume_i SHALL have priority over step_i.
REQ-031 FETCH_CTRL_STEP_EN undefined: step_i port absent; HALTED leaves only via resume_i or reset.

Structure
REQ-032 State enum, NOP_WORD default and instruction width constant SHALL live in shared package cpu_pkg; address width stays `A_BITS.
REQ-033 SHALL be one module, no sub-modules; PC register, IR and FSM in separate always_ff blocks, next-state logic in one always_comb.

Verification
REQ-034 Reset, then 4 idle cycles with mem[i]=i+0x100 -> fetch_instruction_o sequence NOP,0x100,0x101,0x102; pc_o 0,0,1,2,3.
REQ-035 In RUN at pc=5, jmp_i=1, jmp_addr_i=0x20 -> next cycle pc_o=0x20, IR=NOP_WORD; following cycle IR=mem[0x20].
REQ-036 stall_i high 3 cycles with jmp_i also high -> pc_o and IR frozen; jump taken on the first cycle after stall_i falls.
REQ-037 halt_i at pc=7 -> halted_o=1, pc_o=7 held 10 cycles; resume_i -> pc_o=8 next cycle.
REQ-038 pc_o all-ones, sequential -> pc_o=0; with FETCH_CTRL_STEP_EN, two step_i pulses in HALTED -> pc_o +2, halted_o stays 1.
REQ-039 rst_i pulse while HALTED and during a jump cycle -> pc_o=RESET_PC, state_o=0, IR=NOP_WORD next cycle.
